// File: rtl/sprite_motion_ctrl.sv
// Sprite motion controller: moves a sprite centre once per frame
// during vertical blanking and reflects it off the screen edges.
module sprite_motion_ctrl #(
   parameter int RADIUS   = 64,
   parameter int H_ACTIVE = 1280,
   parameter int V_ACTIVE = 720,
   parameter int X_INIT   = 640,
   parameter int Y_INIT   = 360
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        start_in,
   input  logic        stop_in,
   input  logic [3:0]  dx_in,
   input  logic [3:0]  dy_in,
   output logic [10:0] x_out,
   output logic [9:0]  y_out,
   output logic        moving_out,
   output logic        bounce_out
);

   localparam logic signed [11:0] XMIN = 12'(RADIUS);
   localparam logic signed [11:0] XMAX = 12'(H_ACTIVE - 1 - RADIUS);
   localparam logic signed [11:0] YMIN = 12'(RADIUS);
   localparam logic signed [11:0] YMAX = 12'(V_ACTIVE - 1 - RADIUS);

   localparam logic [10:0] XMIN_W = 11'(RADIUS);
   localparam logic [10:0] XMAX_W = 11'(H_ACTIVE - 1 - RADIUS);
   localparam logic [9:0]  YMIN_W = 10'(RADIUS);
   localparam logic [9:0]  YMAX_W = 10'(V_ACTIVE - 1 - RADIUS);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_FRAME,
      STEP_X,
      STEP_Y,
      COMMIT
   } state_t;

   state_t state;

   logic [3:0]  dx_lat;
   logic [3:0]  dy_lat;
   logic        dir_x;
   logic        dir_y;
   logic [10:0] x_nxt;
   logic [9:0]  y_nxt;
   logic        bounce_x;
   logic        bounce_y;
   logic        stop_pend;

   logic               frame_tick;
   logic signed [11:0] x_sum;
   logic signed [11:0] y_sum;
   logic               x_hit;
   logic               y_hit;
   logic [10:0]        x_step;
   logic [9:0]         y_step;

   assign frame_tick = (hcount_in == 11'd0) &&
                       (vcount_in == 10'(V_ACTIVE));

   // Candidate next position per axis; dir=0 means moving towards max.
   always_comb begin
      x_sum  = $signed({1'b0, x_out});
      y_sum  = $signed({2'b00, y_out});
      x_hit  = 1'b0;
      y_hit  = 1'b0;
      x_step = x_out;
      y_step = y_out;
      if (dir_x)
         x_sum = x_sum - $signed({8'd0, dx_lat});
      else
         x_sum = x_sum + $signed({8'd0, dx_lat});
      if (dir_y)
         y_sum = y_sum - $signed({8'd0, dy_lat});
      else
         y_sum = y_sum + $signed({8'd0, dy_lat});
      if (dx_lat != 4'd0)
         x_hit = dir_x ? (x_sum <= XMIN) : (x_sum >= XMAX);
      if (dy_lat != 4'd0)
         y_hit = dir_y ? (y_sum <= YMIN) : (y_sum >= YMAX);
      if (x_hit)
         x_step = dir_x ? XMIN_W : XMAX_W;
      else
         x_step = x_sum[10:0];
      if (y_hit)
         y_step = dir_y ? YMIN_W : YMAX_W;
      else
         y_step = y_sum[9:0];
   end

   // Motion FSM with registered position, moving and bounce outputs.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state      <= IDLE;
         x_out      <= 11'(X_INIT);
         y_out      <= 10'(Y_INIT);
         dir_x      <= 1'b0;
         dir_y      <= 1'b0;
         dx_lat     <= 4'd0;
         dy_lat     <= 4'd0;
         x_nxt      <= 11'd0;
         y_nxt      <= 10'd0;
         bounce_x   <= 1'b0;
         bounce_y   <= 1'b0;
         stop_pend  <= 1'b0;
         moving_out <= 1'b0;
         bounce_out <= 1'b0;
      end else begin
         bounce_out <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!stop_in && start_in) begin
                  dx_lat     <= dx_in;
                  dy_lat     <= dy_in;
                  state      <= WAIT_FRAME;
                  moving_out <= 1'b1;
               end
            end
            WAIT_FRAME: begin
               if (stop_in) begin
                  state      <= IDLE;
                  moving_out <= 1'b0;
               end else if (frame_tick) begin
                  state <= STEP_X;
               end
            end
            STEP_X: begin
               x_nxt    <= x_step;
               bounce_x <= x_hit;
               if (x_hit)
                  dir_x <= ~dir_x;
               if (stop_in)
                  stop_pend <= 1'b1;
               state <= STEP_Y;
            end
            STEP_Y: begin
               y_nxt    <= y_step;
               bounce_y <= y_hit;
               if (y_hit)
                  dir_y <= ~dir_y;
               if (stop_in)
                  stop_pend <= 1'b1;
               state <= COMMIT;
            end
            COMMIT: begin
               x_out      <= x_nxt;
               y_out      <= y_nxt;
               bounce_out <= bounce_x | bounce_y;
               bounce_x   <= 1'b0;
               bounce_y   <= 1'b0;
               stop_pend  <= 1'b0;
               if (stop_pend || stop_in) begin
                  state      <= IDLE;
                  moving_out <= 1'b0;
               end else begin
                  state <= WAIT_FRAME;
               end
            end
            default: begin
               state      <= IDLE;
               moving_out <= 1'b0;
            end
         endcase
      end
   end

endmodule
